// File: rtl/grid_canvas_if.sv
// grid_canvas_if: keyboard, paint control, readout stream and VGA pixel signals
// of grid_canvas. Names carry the direction seen from the canvas (slave side).
interface grid_canvas_if #(
  parameter int PIX_BITS = 1
);
  logic [7:0]          i_scan_code;
  logic                i_scan_valid;
  logic                i_brush_en;
  logic                i_erase_en;
  logic                i_clear_req;
  logic                i_rd_start;
  logic                i_out_ready;
  logic                o_out_valid;
  logic [PIX_BITS-1:0] o_out_data;
  logic                o_out_last;
  logic                o_busy;
  logic [4:0]          o_cursor_x;
  logic [4:0]          o_cursor_y;
  logic [7:0]          o_vga_x;
  logic [6:0]          o_vga_y;
  logic [2:0]          o_vga_colour;
  logic                o_vga_plot;

  modport master (
    output i_scan_code, i_scan_valid, i_brush_en, i_erase_en,
           i_clear_req, i_rd_start, i_out_ready,
    input  o_out_valid, o_out_data, o_out_last, o_busy, o_cursor_x, o_cursor_y,
           o_vga_x, o_vga_y, o_vga_colour, o_vga_plot
  );

  modport slave (
    input  i_scan_code, i_scan_valid, i_brush_en, i_erase_en,
           i_clear_req, i_rd_start, i_out_ready,
    output o_out_valid, o_out_data, o_out_last, o_busy, o_cursor_x, o_cursor_y,
           o_vga_x, o_vga_y, o_vga_colour, o_vga_plot
  );
endinterface

// File: rtl/grid_canvas.sv
// grid_canvas: PS/2 scan codes move a cursor over a cell grid, brush/erase
// paint the cell under it, a free-running scanner rasterises the grid to the
// VGA pixel port and a readout stream dumps the canvas in raster order.
//
// state   | meaning
// S_CLEAR | zeroing one cell per cycle, busy
// S_IDLE  | moves and painting active
// S_READ  | streaming cells 0..N-1, canvas and cursor frozen, busy
module grid_canvas #(
  parameter int GRID_W    = 28,
  parameter int GRID_H    = 28,
  parameter int CELL_PX   = 4,
  parameter int PIX_BITS  = 1,
  parameter int DELAY_MAX = 2000000
) (
  input  logic         i_clk,
  input  logic         i_reset,
  grid_canvas_if.slave io_bus
);
  localparam int N   = GRID_W * GRID_H;
  localparam int AW  = $clog2(N);
  localparam int HW  = (DELAY_MAX > 0) ? $clog2(DELAY_MAX + 1) : 1;
  localparam int CSH = $clog2(CELL_PX);

  localparam logic [AW-1:0] A_LAST  = AW'(N - 1);
  localparam logic [7:0]    PX_LAST = 8'(GRID_W * CELL_PX - 1);
  localparam logic [6:0]    PY_LAST = 7'(GRID_H * CELL_PX - 1);
  localparam logic [4:0]    X_MAX   = 5'(GRID_W - 1);
  localparam logic [4:0]    Y_MAX   = 5'(GRID_H - 1);
  localparam logic [HW-1:0] H_LOAD  = HW'(DELAY_MAX);

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_READ} state_t;

  state_t              r_state;
  logic [PIX_BITS-1:0] r_mem [N];
  logic [AW-1:0]       r_clr_addr;
  logic [AW-1:0]       r_rd_addr;
  logic                r_busy;
  logic                r_out_valid;
  logic [4:0]          r_cur_x;
  logic [4:0]          r_cur_y;
  logic [HW-1:0]       r_holdoff;
  logic                r_brk;
  logic [7:0]          r_px;
  logic [6:0]          r_py;
  logic [7:0]          r_vga_x;
  logic [6:0]          r_vga_y;
  logic [2:0]          r_vga_colour;
  logic                r_vga_plot;

  logic                w_term;
  logic                w_step;
  logic                w_move;
  logic [4:0]          w_nx;
  logic [4:0]          w_ny;
  logic [AW-1:0]       w_cur_addr;
  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [PIX_BITS-1:0] w_wdata;
  logic [7:0]          w_cell_x;
  logic [6:0]          w_cell_y;
  logic [AW-1:0]       w_scan_addr;
  logic                w_on_cursor;
  logic [2:0]          w_colour;

  assign w_cur_addr  = AW'(32'(r_cur_y) * GRID_W + 32'(r_cur_x));
  assign w_cell_x    = r_px >> CSH;
  assign w_cell_y    = r_py >> CSH;
  assign w_scan_addr = AW'(32'(w_cell_y) * GRID_W + 32'(w_cell_x));
  assign w_on_cursor = (w_cell_x == {3'b000, r_cur_x}) && (w_cell_y == {2'b00, r_cur_y});

  // Decode a terminal scan code into a clamped cursor step. The E0 prefix only
  // distinguishes keypad from cursor-block arrows, which move identically, so
  // only the break flag affects the decision.
  always_comb begin
    w_term = io_bus.i_scan_valid && (io_bus.i_scan_code != SC_EXT)
             && (io_bus.i_scan_code != SC_BRK);
    w_nx   = r_cur_x;
    w_ny   = r_cur_y;
    w_step = 1'b0;
    if (w_term && !r_brk) begin
      case (io_bus.i_scan_code)
        SC_LEFT:  if (r_cur_x != 5'd0)  begin w_nx = r_cur_x - 5'd1; w_step = 1'b1; end
        SC_RIGHT: if (r_cur_x != X_MAX) begin w_nx = r_cur_x + 5'd1; w_step = 1'b1; end
        SC_UP:    if (r_cur_y != 5'd0)  begin w_ny = r_cur_y - 5'd1; w_step = 1'b1; end
        SC_DOWN:  if (r_cur_y != Y_MAX) begin w_ny = r_cur_y + 5'd1; w_step = 1'b1; end
        default: ;
      endcase
    end
    w_move = w_step && (r_state == S_IDLE) && (r_holdoff == '0);
  end

  // Single write port: clear sweep, else brush (wins) or erase at the cursor.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
    end else if (r_state == S_IDLE) begin
      if (io_bus.i_brush_en) begin
        w_we    = 1'b1;
        w_waddr = w_cur_addr;
        w_wdata = '1;
      end else if (io_bus.i_erase_en) begin
        w_we    = 1'b1;
        w_waddr = w_cur_addr;
      end
    end
  end

  // Cell storage; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Main FSM with registered busy/out_valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_CLEAR;
      r_clr_addr  <= '0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_addr == A_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
          end
        end
        S_IDLE: begin
          if (io_bus.i_clear_req) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
          end else if (io_bus.i_rd_start) begin
            r_state     <= S_READ;
            r_rd_addr   <= '0;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        S_READ: begin
          if (io_bus.i_out_ready) begin
            if (r_rd_addr == A_LAST) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
            end else begin
              r_rd_addr <= r_rd_addr + AW'(1);
            end
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Scan-code flag, cursor position and move hold-off counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cur_x   <= 5'(GRID_W / 2);
      r_cur_y   <= 5'(GRID_H / 2);
      r_holdoff <= '0;
      r_brk     <= 1'b0;
    end else begin
      if (io_bus.i_scan_valid) begin
        if (io_bus.i_scan_code == SC_BRK) r_brk <= 1'b1;
        else if (w_term)                  r_brk <= 1'b0;
      end
      if (w_move) begin
        r_cur_x   <= w_nx;
        r_cur_y   <= w_ny;
        r_holdoff <= H_LOAD;
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - HW'(1);
      end
    end
  end

  assign w_colour = w_on_cursor ? 3'b100 :
                    (r_mem[w_scan_addr] != '0) ? 3'b111 : 3'b001;

  // Raster scanner; coordinates and colour are registered together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_px         <= '0;
      r_py         <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_vga_x      <= r_px;
      r_vga_y      <= r_py;
      r_vga_colour <= w_colour;
      r_vga_plot   <= 1'b1;
      if (r_px == PX_LAST) begin
        r_px <= '0;
        r_py <= (r_py == PY_LAST) ? 7'd0 : r_py + 7'd1;
      end else begin
        r_px <= r_px + 8'd1;
      end
    end
  end

  assign io_bus.o_busy       = r_busy;
  assign io_bus.o_out_valid  = r_out_valid;
  assign io_bus.o_out_data   = r_out_valid ? r_mem[r_rd_addr] : '0;
  assign io_bus.o_out_last   = r_out_valid && (r_rd_addr == A_LAST);
  assign io_bus.o_cursor_x   = r_cur_x;
  assign io_bus.o_cursor_y   = r_cur_y;
  assign io_bus.o_vga_x      = r_vga_x;
  assign io_bus.o_vga_y      = r_vga_y;
  assign io_bus.o_vga_colour = r_vga_colour;
  assign io_bus.o_vga_plot   = r_vga_plot;
endmodule

// File: doc/grid_canvas.md
# grid_canvas

Parametrised drawing canvas for the digit-input path: decodes PS/2 keyboard scan codes into cursor moves on a GRID_W×GRID_H cell grid and paints or erases cells. It continuously rasterises the grid to the vga_adapter pixel port, and on request streams the canvas in raster order to the inference datapath. It sits between ps2_keyboard and vga_adapter and replaces the fixed 28×28 single-mode canvas logic in the top level.

## Interface
- GRID_W, 28, grid width in cells (2..32)
- GRID_H, 28, grid height in cells (2..32)
- CELL_PX, 4, VGA pixels per cell edge, power of two; GRID_W*CELL_PX ≤ 160, GRID_H*CELL_PX ≤ 120
- PIX_BITS, 1, bits per cell (intensity); paint writes all ones, erase writes zero
- DELAY_MAX, 2000000, hold-off cycles after an accepted move
- clk  in  1  system clock (50 MHz); single clock domain
- reset  in  1  synchronous, active-high
- scan_code  in  8  PS/2 byte from ps2_keyboard
- scan_valid  in  1  one-cycle strobe, scan_code valid
- brush_en  in  1  level, paint cell under cursor
- erase_en  in  1  level, erase cell under cursor (brush_en wins)
- clear_req  in  1  pulse, clear whole canvas
- rd_start  in  1  pulse, begin canvas readout
- out_ready  in  1  readout sink ready
- out_valid  out  1  readout word valid
- out_data  out  PIX_BITS  readout cell value
- out_last  out  1  marks final cell (index GRID_W*GRID_H−1)
- busy  out  1  clear or readout in progress
- cursor_x  out  5  cursor column
- cursor_y  out  5  cursor row
- vga_x  out  8  pixel x to vga_adapter
- vga_y  out  7  pixel y to vga_adapter
- vga_colour  out  3  pixel colour {R,G,B}
- vga_plot  out  1  pixel write enable

## Operation
- Storage: GRID_W*GRID_H cells of PIX_BITS each. Address = y*GRID_W + x. One write port; independent read paths for the scanner and for readout.
- Main FSM states:
  - CLEAR: write 0 to one address per cycle, 0..N−1, then go to IDLE. Entered from reset and on clear_req in IDLE.
  - IDLE: moves and paint are active.
  - READ: entered on rd_start in IDLE.
- busy = 1 in CLEAR and READ.
- Scan decoder runs in every state and tracks two flags, ext (after E0) and brk (after F0).
- On scan_valid:
  - E0 sets ext; F0 sets brk.
  - Any other byte is a terminal code; ext and brk clear on it.
  - A terminal code is a move only if brk = 0 and the code is 6B/74/75/72 (left/right/up/down). The E0 prefix is optional.
  - Break sequences (F0 xx, E0 F0 xx) never move the cursor.
- Moves:
  - Applied only in IDLE with holdoff = 0.
  - Clamp at the edges (0..GRID_W−1, 0..GRID_H−1). A clamped key does not load holdoff.
  - An accepted move loads holdoff = DELAY_MAX, which counts down 1 per cycle. Moves while holdoff ≠ 0 are dropped.
- Paint: in IDLE, each cycle:
  - brush_en writes all ones at the current cursor address.
  - else erase_en writes 0.
  - A move and a write in the same cycle: the write uses the pre-move cursor.
- clear_req and rd_start are ignored outside IDLE. If both are asserted in IDLE, clear_req wins.
- READ:
  - Presents cells 0..N−1 in order. Advance only on out_valid & out_ready.
  - out_last = 1 with cell N−1. Its handshake returns to IDLE.
  - Canvas and cursor are frozen for the duration.
- Scanner:
  - Free-running over px 0..GRID_W*CELL_PX−1 and py 0..GRID_H*CELL_PX−1, one pixel per cycle, x fastest. Wraps to (0,0) after the last pixel.
  - Cell = (px/CELL_PX, py/CELL_PX).
  - Colour: cursor cell 3'b100; nonzero cell 3'b111; else 3'b001.

## Timing
- Reset values:
  - cursor = (GRID_W/2, GRID_H/2), holdoff = 0, ext = brk = 0.
  - busy = 1 (CLEAR follows reset).
  - out_valid = out_last = 0, out_data = 0.
  - vga_x = vga_y = 0, vga_colour = 0, vga_plot = 0.
- Reset mid-operation aborts any clear or readout and restarts CLEAR. busy falls exactly N cycles after reset deasserts.
- Move latency: cursor updates on the edge after the terminal scan_valid cycle.
- Paint latency: a cell write is visible to the scanner and to readout on the next cycle.
- VGA pipeline: 1 cycle. vga_x, vga_y and vga_colour are registered together, so coordinates and colour always refer to the same pixel. vga_plot = 1 from the first cycle after reset and stays high.
- Readout:
  - out_valid rises the cycle after rd_start.
  - out_data/out_valid hold stable while out_ready = 0.
  - Full throughput: 1 cell/cycle with out_ready held high.
  - busy falls the cycle after the out_last handshake.

## Test plan
- Reset, then wait: busy high for 784 cycles (28×28) then low. cursor = (14,14). Every scanned pixel is 3'b001 except the 4×4 cursor block at (56..59, 56..59), which is 3'b100.
- Send E0 74 (right), then E0 F0 74 (break), DELAY_MAX = 4: cursor_x 14→15 once. Break causes no move. A second E0 74 sent 2 cycles later is dropped; one sent 5 cycles later moves to 16.
- Send left ×20 with cursor at (1,14) and holdoff expired between keys: cursor_x stops at 0 and holdoff stays 0 on the clamped key.
- brush_en at (3,5) for 1 cycle, then erase_en at (4,5) with brush_en high: cell 143 = 1 and cell 144 = 1 (brush priority). Both brush and erase off: no writes.
- Paint cells 0 and 783, then rd_start with out_ready toggling 1,0,1,…: 784 words; word 0 = 1, word 783 = 1 with out_last, others 0. Data stable during stalls. Keys sent during readout are ignored.
- clear_req asserted while in READ: ignored. Then clear_req in IDLE: all cells 0 after 784 cycles. Asserting reset halfway through a clear restarts the full 784-cycle sweep.
